// File: rtl/ltc_serial_pkg.sv
// Shared definitions for the host work link (receive and transmit sides).
//   rx_state_e      : receiver byte FSM states
//   WORK_BYTES_DEF  : default getwork frame length in bytes
//   bit_div/half_div: clocks per bit and per half bit from clock and baud rate
package ltc_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned WORK_BYTES_DEF = 84;

  // Truncating division: the receiver runs slightly fast, never slow.
  function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned half_div(input int unsigned clk_hz, input int unsigned baud);
    return bit_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/serial_work_receive_if.sv
// Work-link bundle between the RxD pin side and the hashing cores.
//   RxD       : serial line, idle high
//   data      : last complete frame, first byte in the top byte
//   rx_done   : one-cycle pulse, data updated on the same edge
//   frame_err : one-cycle pulse on a bad stop bit
//   timeout   : one-cycle pulse when a partial frame is discarded
// master = line driver / frame consumer, slave = receiver.
interface serial_work_receive_if
  import ltc_serial_pkg::*;
#(
  parameter int unsigned WORK_BYTES = WORK_BYTES_DEF
);
  localparam int unsigned DW = 8 * WORK_BYTES;

  logic          RxD;
  logic [DW-1:0] data;
  logic          rx_done;
  logic          frame_err;
  logic          timeout;

  modport master (output RxD, input data, input rx_done, input frame_err, input timeout);
  modport slave  (input RxD, output data, output rx_done, output frame_err, output timeout);
endinterface

// File: rtl/serial_rx_byte.sv
// 8N1 byte receiver: RxD synchroniser, start/data/stop FSM and bit timing.
// Ports:
//   clk, rstn     : clock, async active-low reset
//   i_rxd         : raw serial input
//   o_byte        : last received byte (LSB arrives first)
//   o_byte_valid  : one-cycle pulse, byte had a good stop bit
//   o_frame_err   : one-cycle pulse, stop bit sampled low
//   o_idle_c      : FSM in IDLE (only with SERIAL_RX_TIMEOUT_EN)
module serial_rx_byte
  import ltc_serial_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 100_000_000,
  parameter int unsigned baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
`ifdef SERIAL_RX_TIMEOUT_EN
  ,
  output logic       o_idle_c
`endif
);
  localparam int unsigned BIT_DIV  = bit_div(comm_clk_frequency, baud_rate);
  localparam int unsigned HALF_DIV = half_div(comm_clk_frequency, baud_rate);
  localparam int unsigned CNT_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  rx_state_e        r_state;
  logic [1:0]       r_sync;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_byte;
  logic             r_byte_valid;
  logic             r_frame_err;
  logic             r_brk;

  logic w_rx;
  logic w_fall;
  logic w_bit_end;
  logic w_half_end;

  assign w_rx       = r_sync[1];
  assign w_fall     = r_rx_prev & ~w_rx;
  assign w_bit_end  = (r_cnt == CNT_W'(BIT_DIV - 1));
  assign w_half_end = (r_cnt == CNT_W'(HALF_DIV - 1));

  // Synchroniser, edge history and byte FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_sync       <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_brk        <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_rxd};
      r_rx_prev    <= w_rx;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          // Mid start bit: a high line here was only a glitch.
          if (w_half_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt  <= '0;
            r_byte <= {w_rx, r_byte[7:1]};
            r_bit  <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // After a bad stop bit, hold here until the line is back high.
          if (r_brk) begin
            if (w_rx) begin
              r_brk   <= 1'b0;
              r_state <= IDLE;
            end
          end else if (w_bit_end) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_byte_valid <= 1'b1;
              r_state      <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_brk       <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
`ifdef SERIAL_RX_TIMEOUT_EN
  assign o_idle_c     = (r_state == IDLE);
`endif

endmodule

// File: rtl/serial_work_receive.sv
// Miner-side work link: assembles 8N1 bytes from RxD into WORK_BYTES-byte
// getwork frames and presents each complete frame on data with rx_done.
// Ports:
//   clk, rstn : clock, async active-low reset
//   bus       : serial_work_receive_if.slave (RxD in; data, rx_done,
//               frame_err, timeout out)
// Build option: SERIAL_RX_TIMEOUT_EN discards a partial frame after
// TIMEOUT_BITS idle bit-times; without it timeout is constant 0.
module serial_work_receive
  import ltc_serial_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 100_000_000,
  parameter int unsigned baud_rate          = 115_200,
  parameter int unsigned WORK_BYTES         = WORK_BYTES_DEF
`ifdef SERIAL_RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_BITS       = 64
`endif
) (
  input logic                  clk,
  input logic                  rstn,
  serial_work_receive_if.slave bus
);
  localparam int unsigned DW   = 8 * WORK_BYTES;
  localparam int unsigned SH_W = DW - 8;
  localparam int unsigned BC_W = $clog2(WORK_BYTES);

  logic [7:0]      w_byte;
  logic            w_byte_valid;
  logic            w_frame_err;
  logic            w_last;
  logic            w_to_hit;

  logic [BC_W-1:0] r_byte_cnt;
  logic [SH_W-1:0] r_shift;
  logic [DW-1:0]   r_data;
  logic            r_rx_done;
  logic            r_timeout;

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int unsigned BIT_DIV = bit_div(comm_clk_frequency, baud_rate);
  localparam int unsigned TO_CYC  = TIMEOUT_BITS * BIT_DIV;
  localparam int unsigned TO_W    = $clog2(TO_CYC);

  logic            w_idle;
  logic [TO_W-1:0] r_idle_cnt;
`endif

  serial_rx_byte #(
    .comm_clk_frequency (comm_clk_frequency),
    .baud_rate          (baud_rate)
  ) u_rx_byte (
    .clk          (clk),
    .rstn         (rstn),
    .i_rxd        (bus.RxD),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
`ifdef SERIAL_RX_TIMEOUT_EN
    ,
    .o_idle_c     (w_idle)
`endif
  );

  assign w_last = (r_byte_cnt == BC_W'(WORK_BYTES - 1));

`ifdef SERIAL_RX_TIMEOUT_EN
  assign w_to_hit = w_idle && (r_byte_cnt != '0) && (r_idle_cnt == TO_W'(TO_CYC - 1));

  // Idle time with a partial frame pending; leaving IDLE (start edge) clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle_cnt <= '0;
    end else if (!w_idle || (r_byte_cnt == '0) || w_to_hit) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Frame assembly; data only changes when the last byte of a frame lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_rx_done  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      r_timeout <= w_to_hit;
      if (w_byte_valid) begin
        if (w_last) begin
          r_data     <= {r_shift, w_byte};
          r_rx_done  <= 1'b1;
          r_shift    <= '0;
          r_byte_cnt <= '0;
        end else begin
          r_shift    <= {r_shift[SH_W-9:0], w_byte};
          r_byte_cnt <= r_byte_cnt + BC_W'(1);
        end
      end else if (w_to_hit) begin
        r_shift    <= '0;
        r_byte_cnt <= '0;
      end
    end
  end

  assign bus.data      = r_data;
  assign bus.rx_done   = r_rx_done;
  assign bus.frame_err = w_frame_err;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_serial_work_receive.sv
// Randomised bench for serial_work_receive: bit-bangs 8N1 bytes on RxD and
// compares frames, pulse counts and held data against a byte-queue model.
module tb_serial_work_receive;
  localparam int unsigned WB     = 84;
  localparam int unsigned DW     = 8 * WB;
  localparam int unsigned BIT    = 1_000_000 / 115_200;
  localparam int unsigned TO_CYC = 64 * BIT;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  serial_work_receive_if #(.WORK_BYTES(WB)) bus ();

  serial_work_receive #(
    .comm_clk_frequency (1_000_000),
    .baud_rate          (115_200),
    .WORK_BYTES         (WB)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bytes of the frame in progress, frames owed.
  logic [7:0]    part[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_frame = '0;
  int exp_done = 0, exp_ferr = 0, exp_to = 0;
  int n_done   = 0, n_ferr   = 0, n_to   = 0;
  bit all_done = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    logic [DW-1:0] f;
    part.push_back(b);
    if (part.size() == WB) begin
      f = '0;
      foreach (part[i]) f = {f[DW-9:0], part[i]};
      exp_q.push_back(f);
      last_frame = f;
      exp_done++;
      part.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good);
    if (good) model_accept(b);
    else      exp_ferr++;
    bus.RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RxD = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.RxD = good;
    repeat (BIT) @(negedge clk);
    bus.RxD = 1'b1;
    if (!good) repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic send_random(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send_byte(8'($urandom), 1'b1);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
`ifdef SERIAL_RX_TIMEOUT_EN
    if (part.size() != 0 && n >= TO_CYC + 8) begin
      exp_to++;
      part.delete();
    end
`endif
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", bus.data, '0);
    check("rst_rx_done", DW'(bus.rx_done), '0);
    check("rst_frame_err", DW'(bus.frame_err), '0);
    check("rst_timeout", DW'(bus.timeout), '0);
    part.delete();
    exp_q.delete();
    last_frame = '0;
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_test(input string name);
    repeat (4 * BIT) @(negedge clk);
    check({name, "_rx_done_cnt"}, DW'(n_done), DW'(exp_done));
    check({name, "_frame_err_cnt"}, DW'(n_ferr), DW'(exp_ferr));
    check({name, "_timeout_cnt"}, DW'(n_to), DW'(exp_to));
    check({name, "_frames_owed"}, DW'(exp_q.size()), '0);
    check({name, "_data_held"}, bus.data, last_frame);
  endtask

  // Every rx_done must deliver the oldest frame the model owes.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rx_done) begin
        n_done++;
        if (exp_q.size() == 0) check("spurious_rx_done", DW'(bus.rx_done), '0);
        else                   check("frame_data", bus.data, exp_q.pop_front());
      end
      if (bus.frame_err) n_ferr++;
      if (bus.timeout)   n_to++;
    end
  end

  initial begin
    repeat (75000) @(posedge clk);
    check("watchdog_finished", DW'(all_done), DW'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] t1 [WB];
    bus.RxD = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: fixed head/tail frame, back-to-back bytes
    for (int i = 0; i < WB; i++) t1[i] = 8'($urandom);
    t1[0] = 8'h00; t1[1] = 8'h00; t1[2] = 8'h07; t1[3] = 8'hff;
    t1[WB-4] = 8'h01; t1[WB-3] = 8'h00; t1[WB-2] = 8'h00; t1[WB-1] = 8'h00;
    for (int i = 0; i < WB; i++) send_byte(t1[i], 1'b1);
    check_test("t1");
    check("t1_head", DW'(bus.data[DW-1 -: 32]), DW'(32'h000007ff));
    check("t1_tail", DW'(bus.data[31:0]), DW'(32'h01000000));

    // 2: two random frames with random inter-byte gaps
    send_random(WB, 3);
    repeat (2 * BIT) @(negedge clk);
    check("t2_between", bus.data, last_frame);
    send_random(WB, 3);
    check_test("t2");

    // 3: short low glitch while idle
    bus.RxD = 1'b0;
    repeat (2) @(negedge clk);
    bus.RxD = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_test("t3");

    // 4: bad stop bit, then a full good frame
    send_byte(8'h5A, 1'b0);
    send_random(WB, 2);
    check_test("t4");

    // 5: partial frame, long idle, then a full frame
    send_random(40, 2);
    idle_cycles(TO_CYC + BIT);
    send_random(WB, 2);
    check_test("t5");

    // 6: reset part way through a frame, then a fresh frame
    send_random(50, 2);
    do_reset();
    check_test("t6_rst");
    send_random(WB, 2);
    check_test("t6");

    all_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
